icache_line_responder: RTL

- Responder side of the CPU→ICache fetch interface.
- Accepts `req_cpu_icache_t` fetch requests from the fetch stage and returns `req_icache_cpu_t` responses: 128-bit line plus exception.
- Holds a single-line buffer. A hit is served in 1 cycle; a miss is refilled from a backing line memory over a valid/ready request and valid-only response interface.
- Sits between if_stage and the L2/memory port; used in simulation and FPGA bring-up builds.

---
 rtl/icache_line_responder_pkg.sv | 66 ++++++
 rtl/icache_line_buffer.sv | 43 ++++
 rtl/icache_line_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/icache_line_responder_pkg.sv
// Shared fetch-interface types for the icache line responder: requests, responses, refill port, FSM states.
// No logic or latency of its own; helper functions are purely combinational.
// No flow control here; handshakes are defined by the modules that use these types.
package icache_line_responder_pkg;

    localparam int ADDR_SIZE               = 40;
    localparam int ICACHE_LINE_OFFSET_BITS = 4;

    typedef logic [ADDR_SIZE-1:0]                         addr_t;
    typedef logic [63:0]                                  bus64_t;
    typedef logic [127:0]                                 icache_line_t;
    typedef logic [ADDR_SIZE-ICACHE_LINE_OFFSET_BITS-1:0] icache_tag_t;

    typedef enum logic [63:0] {
        INSTR_ADDR_MISALIGNED = 64'd0,
        INSTR_ACCESS_FAULT    = 64'd1
    } exception_cause_t;

    typedef struct packed {
        exception_cause_t cause;
        bus64_t           origin;
        logic             valid;
    } exception_t;

    typedef struct packed {
        logic  valid;
        addr_t vaddr;
    } req_cpu_icache_t;

    typedef struct packed {
        logic         valid;
        icache_line_t data;
        exception_t   ex;
    } req_icache_cpu_t;

    typedef enum logic [1:0] {
        ResetState = 2'd0,
        NoReq      = 2'd1,
        ReqValid   = 2'd2,
        RespReady  = 2'd3
    } icache_state_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } icache_mem_req_t;

    typedef struct packed {
        logic         valid;
        icache_line_t data;
        logic         error;
    } icache_mem_resp_t;

    function automatic icache_tag_t addr_tag(input addr_t a);
        return a[ADDR_SIZE-1:ICACHE_LINE_OFFSET_BITS];
    endfunction

    function automatic logic addr_misaligned(input addr_t a);
        return a[1:0] != 2'b00;
    endfunction

    function automatic bus64_t addr_to_origin(input addr_t a);
        return {{(64-ADDR_SIZE){1'b0}}, a};
    endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Single-line instruction buffer: tag/data/valid registers with a combinational hit compare.
// Lookup is combinational (0 cycles); writes and invalidates take effect at the next clock edge.
// No flow control; invalidate wins over a write issued in the same cycle.
module icache_line_buffer
    import icache_line_responder_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  icache_tag_t  lookup_tag_i,
    output logic         hit_o,
    output icache_line_t line_o,
    input  logic         wr_en_i,
    input  icache_tag_t  wr_tag_i,
    input  icache_line_t wr_data_i,
    input  logic         inval_i
);

    logic         valid_q;
    icache_tag_t  tag_q;
    icache_line_t data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a valid hit.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !inval_i) begin
            tag_q  <= wr_tag_i;
            data_q <= wr_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign line_o = data_q;

endmodule

// File: rtl/icache_line_responder.sv
// ICache responder for the CPU fetch port; one buffered line, refilled from line memory. Option: ICACHE_RESPONDER_STATS_EN.
// Hit/misaligned answer next cycle; miss = 1 + request-wait + response-wait + 1 cycles.
// Responses are single-cycle pulses with no backpressure; icache_ready_o is high only in NoReq without flush.
module icache_line_responder
    import icache_line_responder_pkg::*;
#(
    parameter int LINE_OFFSET_BITS = 4,
    parameter int ADDR_W           = 40
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  req_cpu_icache_t   req_cpu_icache_i,
    input  logic              flush_i,
    output logic              icache_ready_o,
    output req_icache_cpu_t   req_icache_cpu_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_resp_valid_i,
    input  logic [127:0]      mem_resp_data_i,
    input  logic              mem_resp_error_i
`ifdef ICACHE_RESPONDER_STATS_EN
    ,
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o
`endif
);

    icache_state_t    state_q, state_d;
    addr_t            vaddr_q;
    logic             kill_q;
    logic             buf_hit;
    icache_line_t     buf_line;
    logic             misaligned, accept;
    logic             mis_accept, hit_accept, miss_accept;
    logic             resp_take, drop_resp, buf_wr, buf_inval;
    icache_mem_req_t  mem_req;
    icache_mem_resp_t mem_resp;
    req_icache_cpu_t  rsp_d, rsp_q;

    assign mem_resp = '{valid: mem_resp_valid_i, data: mem_resp_data_i, error: mem_resp_error_i};

    assign misaligned  = addr_misaligned(req_cpu_icache_i.vaddr);
    assign accept      = icache_ready_o && req_cpu_icache_i.valid;
    assign mis_accept  = accept && misaligned;
    assign hit_accept  = accept && !misaligned && buf_hit;
    assign miss_accept = accept && !misaligned && !buf_hit;

    // A flush arriving on the very cycle the refill returns still kills it.
    assign resp_take = (state_q == RespReady) && mem_resp.valid;
    assign drop_resp = kill_q || flush_i;
    assign buf_wr    = resp_take && !drop_resp && !mem_resp.error;
    assign buf_inval = flush_i || (resp_take && mem_resp.error);

    icache_line_buffer u_line_buffer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lookup_tag_i (addr_tag(req_cpu_icache_i.vaddr)),
        .hit_o        (buf_hit),
        .line_o       (buf_line),
        .wr_en_i      (buf_wr),
        .wr_tag_i     (addr_tag(vaddr_q)),
        .wr_data_i    (mem_resp.data),
        .inval_i      (buf_inval)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ResetState: state_d = NoReq;
            NoReq:      if (miss_accept)      state_d = ReqValid;
            ReqValid:   if (mem_req_ready_i)  state_d = RespReady;
            RespReady:  if (mem_resp.valid)   state_d = NoReq;
            default:    state_d = ResetState;
        endcase
    end

    always_comb begin
        icache_ready_o = 1'b0;
        mem_req        = '0;
        case (state_q)
            NoReq:    icache_ready_o = !flush_i;
            ReqValid: mem_req.valid  = 1'b1;
            default:  ;
        endcase
        mem_req.addr = {vaddr_q[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    end

    assign mem_req_valid_o = mem_req.valid;
    assign mem_req_addr_o  = mem_req.addr;

    // The request stays asserted through a flush; only the returning line is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vaddr_q <= '0;
            kill_q  <= 1'b0;
        end else if (miss_accept) begin
            vaddr_q <= req_cpu_icache_i.vaddr;
            kill_q  <= 1'b0;
        end else if (flush_i && (state_q == ReqValid || state_q == RespReady)) begin
            kill_q  <= 1'b1;
        end
    end

    always_comb begin
        rsp_d = '0;
        if (mis_accept) begin
            rsp_d.valid     = 1'b1;
            rsp_d.ex.valid  = 1'b1;
            rsp_d.ex.cause  = INSTR_ADDR_MISALIGNED;
            rsp_d.ex.origin = addr_to_origin(req_cpu_icache_i.vaddr);
        end else if (hit_accept) begin
            rsp_d.valid = 1'b1;
            rsp_d.data  = buf_line;
        end else if (resp_take && !drop_resp) begin
            rsp_d.valid = 1'b1;
            if (mem_resp.error) begin
                rsp_d.ex.valid  = 1'b1;
                rsp_d.ex.cause  = INSTR_ACCESS_FAULT;
                rsp_d.ex.origin = addr_to_origin(vaddr_q);
            end else begin
                rsp_d.data = mem_resp.data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign req_icache_cpu_o = rsp_q;

`ifdef ICACHE_RESPONDER_STATS_EN
    // Killed misses are counted at acceptance, so a later flush does not undo them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            if (hit_accept && hit_count_o != 32'hFFFF_FFFF) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if (miss_accept && miss_count_o != 32'hFFFF_FFFF) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
